// File: rtl/homescreen_mode_sequencer.sv
// Frame-synchronous homescreen menu controller: cursor navigation with hold-to-repeat,
// app launch/hand-off, and return home on a held START.
module homescreen_mode_sequencer #(
   parameter int unsigned REPEAT_DELAY  = 20,
   parameter int unsigned REPEAT_RATE   = 8,
   parameter int unsigned EXIT_HOLD     = 60,
   parameter int unsigned LEAVE_TIMEOUT = 120
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       screen_end,
   input  logic [7:0] buttons,
   input  logic       app_busy,
   output logic [1:0] sel,
   output logic [1:0] mode,
   output logic       app_en,
   output logic       app_start,
   output logic [7:0] app_buttons
);

   localparam logic [2:0] ST_HOME    = 3'd0;
   localparam logic [2:0] ST_ENTER   = 3'd1;
   localparam logic [2:0] ST_APP     = 3'd2;
   localparam logic [2:0] ST_LEAVE   = 3'd3;
   localparam logic [2:0] ST_RELEASE = 3'd4;

   localparam logic [1:0] SEL_GAME = 2'b00;
   localparam logic [1:0] SEL_CTRL = 2'b01;
   localparam logic [1:0] SEL_STGS = 2'b10;

   // Winning direction encoded as {valid, code}; 000 means no direction held.
   localparam logic [2:0] DIR_NONE  = 3'b000;
   localparam logic [2:0] DIR_UP    = 3'b100;
   localparam logic [2:0] DIR_DOWN  = 3'b101;
   localparam logic [2:0] DIR_LEFT  = 3'b110;
   localparam logic [2:0] DIR_RIGHT = 3'b111;

   localparam logic [7:0] REP_DELAY_C = 8'(REPEAT_DELAY);
   localparam logic [7:0] REP_RATE_C  = 8'(REPEAT_RATE);
   localparam logic [7:0] EXIT_HOLD_C = 8'(EXIT_HOLD);
   localparam logic [7:0] LEAVE_TO_C  = 8'(LEAVE_TIMEOUT);

   logic [2:0] st;
   logic [7:0] prev;
   logic [7:0] rep_cnt;
   logic       rep_phase;
   logic [2:0] rep_dir;
   logic [7:0] exit_cnt;
   logic [7:0] leave_cnt;

   logic [7:0] new_press;
   logic       confirm;
   logic [2:0] dir;
   logic [7:0] rep_inc;
   logic [7:0] exit_inc;
   logic [7:0] leave_inc;
   logic       same_dir;
   logic       rep_fire;
   logic       move_fire;
   logic       buttons_idle;
   logic       unused_edges;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [2:0] win_dir(input logic [3:0] d);
      if (d[0])      return DIR_UP;
      else if (d[1]) return DIR_DOWN;
      else if (d[2]) return DIR_LEFT;
      else if (d[3]) return DIR_RIGHT;
      else           return DIR_NONE;
   endfunction

   function automatic logic [1:0] move_sel(input logic [1:0] s, input logic [2:0] d);
      logic [1:0] r;
      r = s;
      case (s)
         SEL_GAME: if (d == DIR_DOWN) r = SEL_CTRL;
         SEL_CTRL: begin
            if (d == DIR_UP)         r = SEL_GAME;
            else if (d == DIR_RIGHT) r = SEL_STGS;
         end
         SEL_STGS: begin
            if (d == DIR_UP)        r = SEL_GAME;
            else if (d == DIR_LEFT) r = SEL_CTRL;
         end
         default: r = s;
      endcase
      return r;
   endfunction

   assign new_press    = buttons & ~prev;
   assign confirm      = new_press[4] | new_press[7];
   assign unused_edges = ^{new_press[6:5], new_press[3:0]};
   assign buttons_idle = (buttons == 8'd0);
   assign dir          = win_dir(buttons[3:0]);
   assign rep_inc      = sat_inc(rep_cnt);
   assign exit_inc     = sat_inc(exit_cnt);
   assign leave_inc    = sat_inc(leave_cnt);

   // Repeat runs in two phases: initial delay, then a steady rate after the first repeat.
   assign same_dir  = dir[2] && (dir == rep_dir);
   assign rep_fire  = same_dir && (rep_phase ? (rep_inc == REP_RATE_C) : (rep_inc == REP_DELAY_C));
   assign move_fire = dir[2] && (!same_dir || rep_fire);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st          <= ST_HOME;
         sel         <= SEL_GAME;
         mode        <= 2'b00;
         app_en      <= 1'b0;
         app_start   <= 1'b0;
         app_buttons <= 8'd0;
         prev        <= 8'd0;
         rep_cnt     <= 8'd0;
         rep_phase   <= 1'b0;
         rep_dir     <= DIR_NONE;
         exit_cnt    <= 8'd0;
         leave_cnt   <= 8'd0;
      end else begin
         app_start   <= 1'b0;
         app_buttons <= buttons & {8{st == ST_APP}};
         if (screen_end) begin
            prev <= buttons;
            case (st)
               ST_HOME: begin
                  if (confirm) begin
                     mode      <= sel + 2'd1;
                     st        <= ST_ENTER;
                     rep_cnt   <= 8'd0;
                     rep_phase <= 1'b0;
                     rep_dir   <= DIR_NONE;
                  end else begin
                     if (move_fire) sel <= move_sel(sel, dir);
                     if (!same_dir) begin
                        rep_cnt   <= 8'd0;
                        rep_phase <= 1'b0;
                     end else if (rep_fire) begin
                        rep_cnt   <= 8'd0;
                        rep_phase <= 1'b1;
                     end else begin
                        rep_cnt   <= rep_inc;
                     end
                     rep_dir <= dir;
                  end
               end
               ST_ENTER: begin
                  // Hold off the app until the confirm press has been released.
                  if (buttons_idle) begin
                     app_en    <= 1'b1;
                     app_start <= 1'b1;
                     exit_cnt  <= 8'd0;
                     st        <= ST_APP;
                  end
               end
               ST_APP: begin
                  if (buttons[7]) begin
                     if (exit_inc == EXIT_HOLD_C) begin
                        app_en    <= 1'b0;
                        exit_cnt  <= 8'd0;
                        leave_cnt <= 8'd0;
                        st        <= ST_LEAVE;
                     end else begin
                        exit_cnt  <= exit_inc;
                     end
                  end else begin
                     exit_cnt <= 8'd0;
                  end
               end
               ST_LEAVE: begin
                  if (!app_busy || (leave_inc == LEAVE_TO_C)) begin
                     mode      <= 2'b00;
                     leave_cnt <= 8'd0;
                     st        <= ST_RELEASE;
                  end else begin
                     leave_cnt <= leave_inc;
                  end
               end
               ST_RELEASE: begin
                  if (buttons_idle) begin
                     prev      <= 8'd0;
                     rep_cnt   <= 8'd0;
                     rep_phase <= 1'b0;
                     rep_dir   <= DIR_NONE;
                     st        <= ST_HOME;
                  end
               end
               default: st <= ST_HOME;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_homescreen_mode_sequencer.sv
// Bench for homescreen_mode_sequencer: per-tick expectations queued by the driver,
// popped and compared by a monitor just after each frame-tick edge.
module tb_homescreen_mode_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       screen_end;
   logic [7:0] buttons;
   logic       app_busy;
   logic [1:0] sel;
   logic [1:0] mode;
   logic       app_en;
   logic       app_start;
   logic [7:0] app_buttons;

   int checks = 0;
   int failures = 0;
   int start_pulses = 0;

   typedef struct {
      string      tag;
      logic [1:0] sel;
      logic [1:0] mode;
      logic       en;
      logic       st;
      logic [7:0] ab;
   } exp_t;

   exp_t sb[$];

   logic [1:0] x_sel;
   logic [1:0] x_mode;
   logic       x_en;
   logic       x_st;
   logic [7:0] x_ab;

   homescreen_mode_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .screen_end  (screen_end),
      .buttons     (buttons),
      .app_busy    (app_busy),
      .sel         (sel),
      .mode        (mode),
      .app_en      (app_en),
      .app_start   (app_start),
      .app_buttons (app_buttons)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) if (app_start === 1'b1) start_pulses++;

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         if (screen_end === 1'b1 && sb.size() > 0) begin
            #1;
            e = sb.pop_front();
            chk({e.tag, ".sel"}, 32'(sel), 32'(e.sel));
            chk({e.tag, ".mode"}, 32'(mode), 32'(e.mode));
            chk({e.tag, ".app_en"}, 32'(app_en), 32'(e.en));
            chk({e.tag, ".app_start"}, 32'(app_start), 32'(e.st));
            chk({e.tag, ".app_buttons"}, 32'(app_buttons), 32'(e.ab));
         end
      end
   end

   // One frame tick: drive inputs, queue the expected post-tick outputs, idle two clocks.
   task automatic tk(input logic [7:0] b, input logic busy, input string tag);
      exp_t e;
      e.tag = tag; e.sel = x_sel; e.mode = x_mode; e.en = x_en; e.st = x_st; e.ab = x_ab;
      @(negedge clk);
      buttons    = b;
      app_busy   = busy;
      screen_end = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      screen_end = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      reset = 1'b0; buttons = 8'd0; screen_end = 1'b0; app_busy = 1'b0;
      x_sel = 2'd0; x_mode = 2'd0; x_en = 1'b0; x_st = 1'b0; x_ab = 8'd0;
      repeat (3) @(negedge clk);
      chk("rst.sel", 32'(sel), 0);
      chk("rst.mode", 32'(mode), 0);
      chk("rst.app_en", 32'(app_en), 0);
      chk("rst.app_buttons", 32'(app_buttons), 0);
      reset = 1'b1;
      buttons = 8'h02;
      repeat (3) @(negedge clk);
      chk("post_rst.sel", 32'(sel), 0);
      chk("post_rst.app_start", 32'(app_start), 0);
      buttons = 8'h00;

      // Navigation and direction priority
      x_sel = 2'd1; tk(8'h02, 0, "nav_down");  tk(8'h00, 0, "nav_rel");
      x_sel = 2'd2; tk(8'h08, 0, "nav_right"); tk(8'h00, 0, "nav_rel");
      x_sel = 2'd1; tk(8'h04, 0, "nav_left");  tk(8'h00, 0, "nav_rel");
      x_sel = 2'd2; tk(8'h08, 0, "nav_right"); tk(8'h00, 0, "nav_rel");
      tk(8'h06, 0, "nav_down_over_left"); tk(8'h00, 0, "nav_rel");
      x_sel = 2'd0; tk(8'h01, 0, "nav_up");    tk(8'h00, 0, "nav_rel");
      tk(8'h09, 0, "nav_up_over_right"); tk(8'h00, 0, "nav_rel");

      // Hold-to-repeat never walks past the end of a move chain
      x_sel = 2'd1; tk(8'h02, 0, "to_ctrl"); tk(8'h00, 0, "nav_rel");
      x_sel = 2'd2;
      for (int i = 0; i < 40; i++) tk(8'h08, 0, "rep_right");
      tk(8'h00, 0, "rep_rel");
      x_sel = 2'd0; tk(8'h01, 0, "to_game"); tk(8'h00, 0, "nav_rel");
      x_sel = 2'd1;
      for (int i = 0; i < 40; i++) tk(8'h02, 0, "rep_down");
      tk(8'h00, 0, "rep_rel");

      // A+down together launches CTRL without moving the cursor
      x_mode = 2'd2; tk(8'h12, 0, "simul_confirm");
      tk(8'h12, 0, "enter_hold"); tk(8'h12, 0, "enter_hold");
      x_en = 1'b1; x_st = 1'b1; tk(8'h00, 0, "launch_ctrl"); x_st = 1'b0;
      x_ab = 8'h35; tk(8'h35, 0, "app_fwd");
      x_ab = 8'h80;
      for (int i = 0; i < 59; i++) tk(8'h80, 0, "exit_hold");
      x_en = 1'b0; tk(8'h80, 0, "exit_60th");
      x_mode = 2'd0; x_ab = 8'h00; tk(8'h80, 0, "leave_free");
      tk(8'h80, 0, "release_hold"); tk(8'h00, 0, "release_done");
      x_sel = 2'd2; tk(8'h08, 0, "cursor_kept"); tk(8'h00, 0, "nav_rel");

      // Launch STGS with a held A press
      x_mode = 2'd3; tk(8'h10, 0, "launch_press");
      for (int i = 0; i < 3; i++) tk(8'h10, 0, "launch_hold");
      x_en = 1'b1; x_st = 1'b1; tk(8'h00, 0, "launch_stgs"); x_st = 1'b0;
      chk("start_pulses_2", 32'(start_pulses), 2);

      // START held 59 then released does not exit; 60 does; busy app times out
      x_ab = 8'h80;
      for (int i = 0; i < 59; i++) tk(8'h80, 0, "exit_59");
      x_ab = 8'h00; tk(8'h00, 0, "exit_clear");
      x_ab = 8'h80;
      for (int i = 0; i < 59; i++) tk(8'h80, 0, "exit_hold60");
      x_en = 1'b0; tk(8'h80, 0, "exit_60th_b");
      x_ab = 8'h00;
      for (int i = 0; i < 119; i++) tk(8'h00, 1, "leave_busy");
      x_mode = 2'd0; tk(8'h00, 1, "leave_timeout");
      tk(8'h00, 1, "release_done2");
      x_sel = 2'd0; tk(8'h01, 0, "home_after_timeout"); tk(8'h00, 0, "nav_rel");

      // Reset in the middle of an app
      x_mode = 2'd1; tk(8'h10, 0, "launch_game");
      x_en = 1'b1; x_st = 1'b1; tk(8'h00, 0, "launch_game_rel"); x_st = 1'b0;
      x_ab = 8'h05; tk(8'h05, 0, "game_fwd");
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midrst.app_en", 32'(app_en), 0);
      chk("midrst.mode", 32'(mode), 0);
      chk("midrst.app_buttons", 32'(app_buttons), 0);
      @(negedge clk);
      chk("midrst.sel", 32'(sel), 0);
      buttons = 8'h00;
      reset = 1'b1;
      x_sel = 2'd0; x_mode = 2'd0; x_en = 1'b0; x_ab = 8'h00;
      tk(8'h00, 0, "post_rst_idle");
      x_sel = 2'd1; tk(8'h02, 0, "post_rst_nav");
      chk("start_pulses_3", 32'(start_pulses), 3);
      repeat (2) @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
